pool_max_stage: RTL and testbench

- Downstream neighbour of the convolution datapath.
- Consumes the post-ReLU float32 output stream, one sample per valid cycle, in row-major order over an IFM_SIZE x IFM_SIZE map.
- Performs 2x2, stride-2 max pooling.
- Emits each pooled value with a write address and write strobe, ready to load the next layer's IFM memory directly.

---
 rtl/cnn_pkg.sv | 10 +
 rtl/float_max2.sv | 35 +++
 rtl/pool_max_stage.sv | 137 +++++++++++++
 tb/tb_pool_max_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared float32 definitions for the CNN datapath stages.
package cnn_pkg;

  localparam int FLOAT_WIDTH    = 32;
  localparam int FLOAT_SIGN_BIT = 31;
  localparam logic [FLOAT_WIDTH-1:0] FLOAT_POS_ZERO = 32'h0000_0000;

  typedef logic [FLOAT_WIDTH-1:0] float_t;

endpackage

// File: rtl/float_max2.sv
// Combinational float32 max: sign-magnitude compare on raw bits, ties return in1.
module float_max2
  import cnn_pkg::*;
(
  input  logic [FLOAT_WIDTH-1:0] in1,
  input  logic [FLOAT_WIDTH-1:0] in2,
  output logic [FLOAT_WIDTH-1:0] out
);

  logic                         sign1;
  logic                         sign2;
  logic [FLOAT_SIGN_BIT-1:0]    mag1;
  logic [FLOAT_SIGN_BIT-1:0]    mag2;
  logic                         in2_wins;

  always_comb begin
    sign1    = in1[FLOAT_SIGN_BIT];
    sign2    = in2[FLOAT_SIGN_BIT];
    mag1     = in1[FLOAT_SIGN_BIT-1:0];
    mag2     = in2[FLOAT_SIGN_BIT-1:0];
    in2_wins = 1'b0;
    // +0 and -0 are equal, so the zero-magnitude case must bypass the sign test
    if ((mag1 == '0) && (mag2 == '0)) begin
      in2_wins = 1'b0;
    end else if (sign1 != sign2) begin
      in2_wins = sign1;
    end else if (!sign1) begin
      in2_wins = (mag2 > mag1);
    end else begin
      in2_wins = (mag2 < mag1);
    end
    out = in2_wins ? in2 : in1;
  end

endmodule

// File: rtl/pool_max_stage.sv
// 2x2 stride-2 max pooling over a row-major float32 stream, emitting OFM writes.
// Optional POOL_RELU_EN: clamp negative pooled results to +0 at the output register.
module pool_max_stage
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 28,
  parameter int OFM_SIZE         = IFM_SIZE / 2,
  parameter int ADDRESS_SIZE_OFM = $clog2(OFM_SIZE * OFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pool_clear,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        data_in_valid,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_out_valid,
  output logic [ADDRESS_SIZE_OFM-1:0] ofm_address,
  output logic                        frame_done
);

  localparam int CNT_W = (IFM_SIZE > 2) ? $clog2(IFM_SIZE) : 1;
  localparam int IDX_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  localparam logic [CNT_W-1:0]            LAST_IDX  = CNT_W'(IFM_SIZE - 1);
  localparam logic [ADDRESS_SIZE_OFM-1:0] LAST_ADDR = ADDRESS_SIZE_OFM'(OFM_SIZE * OFM_SIZE - 1);

  if ((IFM_SIZE % 2) != 0) begin : g_odd_ifm
    $error("pool_max_stage: IFM_SIZE must be even");
  end
  if (DATA_WIDTH != FLOAT_WIDTH) begin : g_bad_width
    $error("pool_max_stage: DATA_WIDTH must equal FLOAT_WIDTH");
  end

  logic [CNT_W-1:0]            col_q, col_d;
  logic [CNT_W-1:0]            row_q, row_d;
  float_t                      pair_q, pair_d;
  logic [ADDRESS_SIZE_OFM-1:0] addr_cnt_q, addr_cnt_d;
  float_t                      dout_q, dout_d;
  logic                        dval_q, dval_d;
  logic [ADDRESS_SIZE_OFM-1:0] oaddr_q, oaddr_d;
  logic                        fdone_q, fdone_d;

  float_t                      line_buf [OFM_SIZE];
  logic [IDX_W-1:0]            lb_idx;
  logic                        lb_we;
  float_t                      pair_max;
  float_t                      win_max;

  assign lb_idx = IDX_W'(col_q >> 1);

  float_max2 u_pair_max (
    .in1 (pair_q),
    .in2 (data_in),
    .out (pair_max)
  );

  float_max2 u_win_max (
    .in1 (line_buf[lb_idx]),
    .in2 (pair_max),
    .out (win_max)
  );

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    pair_d     = pair_q;
    addr_cnt_d = addr_cnt_q;
    dout_d     = dout_q;
    oaddr_d    = oaddr_q;
    dval_d     = 1'b0;
    fdone_d    = 1'b0;
    lb_we      = 1'b0;
    if (pool_clear) begin
      col_d      = '0;
      row_d      = '0;
      pair_d     = FLOAT_POS_ZERO;
      addr_cnt_d = '0;
    end else if (data_in_valid) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      if (!col_q[0]) begin
        pair_d = data_in;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
`ifdef POOL_RELU_EN
        dout_d = win_max[FLOAT_SIGN_BIT] ? FLOAT_POS_ZERO : win_max;
`else
        dout_d = win_max;
`endif
        dval_d     = 1'b1;
        oaddr_d    = addr_cnt_q;
        fdone_d    = (addr_cnt_q == LAST_ADDR);
        addr_cnt_d = (addr_cnt_q == LAST_ADDR) ? '0 : addr_cnt_q + ADDRESS_SIZE_OFM'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      pair_q     <= FLOAT_POS_ZERO;
      addr_cnt_q <= '0;
      dout_q     <= '0;
      dval_q     <= 1'b0;
      oaddr_q    <= '0;
      fdone_q    <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      pair_q     <= pair_d;
      addr_cnt_q <= addr_cnt_d;
      dout_q     <= dout_d;
      dval_q     <= dval_d;
      oaddr_q    <= oaddr_d;
      fdone_q    <= fdone_d;
    end
  end

  // Line buffer holds even-row pair maxima; contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf[lb_idx] <= pair_max;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dval_q;
  assign ofm_address    = oaddr_q;
  assign frame_done     = fdone_q;

endmodule

// File: tb/tb_pool_max_stage.sv
// Scoreboard bench for pool_max_stage on a 4x4 map (2x2 pooled).
module tb_pool_max_stage;

  localparam int IFM = 4;
  localparam int OFM = 2;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pool_clear = 1'b0;
  logic [31:0]   data_in = '0;
  logic          data_in_valid = 1'b0;
  logic [31:0]   data_out;
  logic          data_out_valid;
  logic [AW-1:0] ofm_address;
  logic          frame_done;

  pool_max_stage #(
    .DATA_WIDTH (32),
    .IFM_SIZE   (IFM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pool_clear     (pool_clear),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .ofm_address    (ofm_address),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
    logic          last;
    int            stamp;
  } exp_t;

  exp_t        sb[$];
  int          m_col, m_row, m_addr;
  logic [31:0] m_frame [IFM][IFM];

  logic [31:0] ramp [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  function automatic longint key(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    return (key(b) > key(a)) ? b : a;
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef POOL_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    m_addr = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic clr);
    exp_t e;
    data_in_valid = v;
    data_in       = d;
    pool_clear    = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else if (v) begin
      m_frame[m_row][m_col] = d;
      if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
        e.data  = relu(ref_max(ref_max(m_frame[m_row-1][m_col-1], m_frame[m_row-1][m_col]),
                               ref_max(m_frame[m_row][m_col-1], d)));
        e.addr  = AW'(m_addr);
        e.last  = (m_addr == OFM*OFM-1);
        e.stamp = cyc;
        sb.push_back(e);
        m_addr = (m_addr + 1) % (OFM*OFM);
      end
      if (m_col == IFM-1) begin
        m_col = 0;
        m_row = (m_row == IFM-1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    data_in_valid = 1'b0;
    pool_clear    = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] fr [16], input bit toggle);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, fr[i], 1'b0);
      if (toggle) step(1'b0, 32'hDEAD_BEEF, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d outputs missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (data_out_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: data=%h addr=%0d, required no output", data_out, ofm_address);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (e.data[30:0] == 31'h0) begin
            if (data_out[30:0] !== 31'h0) begin
              n_bad++;
              $display("FAIL out_zero: got %h, required magnitude 0", data_out);
            end
          end else if (data_out !== e.data) begin
            n_bad++;
            $display("FAIL out_data: got %h, required %h", data_out, e.data);
          end
          n_cmp++;
          if (ofm_address !== e.addr) begin
            n_bad++;
            $display("FAIL out_addr: got %0d, required %0d", ofm_address, e.addr);
          end
          n_cmp++;
          if (frame_done !== e.last) begin
            n_bad++;
            $display("FAIL frame_done: got %b, required %b", frame_done, e.last);
          end
          if (cyc != e.stamp) begin
            n_bad++;
            $display("FAIL out_latency: output at cycle %0d, required %0d", cyc, e.stamp);
          end
        end
      end else begin
        n_cmp++;
        if (frame_done !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_frame_done: got %b, required 0", frame_done);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if ({data_out, data_out_valid, ofm_address, frame_done} !== '0) begin
      n_bad++;
      $display("FAIL %s: data=%h valid=%b addr=%0d done=%b, required all 0",
               name, data_out, data_out_valid, ofm_address, frame_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_outputs_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp();
    run_frame(ramp, 1'b0);
    drain("ramp");
  endtask

  task automatic test_negative();
    logic [31:0] fr [16];
    logic [31:0] want;
    fr = ramp;
    fr[0] = 32'hBF800000;
    fr[1] = 32'hC0000000;
    fr[4] = 32'hC0400000;
    fr[5] = 32'hBF000000;
`ifdef POOL_RELU_EN
    want = 32'h0000_0000;
`else
    want = 32'hBF00_0000;
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b1, fr[i], 1'b0);
      if (i == 5) begin
        n_cmp++;
        if (data_out !== want || data_out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL negative_window: got %h valid=%b, required %h valid=1", data_out, data_out_valid, want);
        end
      end
    end
    drain("negative");
  endtask

  task automatic test_toggle();
    run_frame(ramp, 1'b1);
    drain("toggle");
  endtask

  task automatic test_signed_zero();
    logic [31:0] fr [16];
    fr = ramp;
    fr[0] = 32'h0000_0000;
    fr[1] = 32'h8000_0000;
    fr[4] = 32'h8000_0000;
    fr[5] = 32'h8000_0000;
    run_frame(fr, 1'b0);
    drain("signed_zero");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) step(1'b1, ramp[i], 1'b0);
    step(1'b1, ramp[5], 1'b1);
    run_frame(ramp, 1'b0);
    drain("clear");
  endtask

  task automatic test_back_to_back();
    logic [31:0] fr [16];
    for (int i = 0; i < 16; i++) fr[i] = ramp[15-i];
    run_frame(ramp, 1'b0);
    run_frame(fr, 1'b0);
    drain("back_to_back");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(1'b1, ramp[i], 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    sb.delete();
    run_frame(ramp, 1'b0);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_toggle();
    test_signed_zero();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
